// File: rtl/ovl_transition_multi.sv
// rtl/ovl_transition_multi.sv - multi-channel forbidden/required state transition checker
module ovl_transition_multi #(
  parameter int NCH      = 2,
  parameter int W        = 2,
  parameter int MODE     = 0,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 8,
  localparam int FCH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [NCH*W-1:0]   test_expr,
  input  logic [NCH*W-1:0]   start_state,
  input  logic [NCH*W-1:0]   next_state,
  output logic [NCH-1:0]     fire,
  output logic [NCH-1:0]     fire_sticky,
  output logic [CNT_W-1:0]   fire_count,
  output logic               first_fail_valid,
  output logic [FCH_W-1:0]   first_fail_ch
);

  localparam int PW    = $clog2(NCH + 1);
  localparam int SUM_W = CNT_W + 6;

  typedef enum logic {S_IDLE, S_ARMED} state_e;

  logic [W-1:0]     cur_w   [NCH];
  logic [W-1:0]     st_w    [NCH];
  logic [W-1:0]     nx_w    [NCH];
  logic [W-1:0]     prev_q  [NCH];
  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [7:0]       wait_q  [NCH];
  logic [7:0]       wait_d  [NCH];
  logic             prev_valid_q;
  logic [NCH-1:0]   viol;
  logic [NCH-1:0]   fire_q;
  logic [NCH-1:0]   sticky_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             ffv_q;
  logic [FCH_W-1:0] ffc_q;
  logic [PW-1:0]    pop;
  logic [FCH_W-1:0] low_ch;
  logic [SUM_W-1:0] sum;

  for (genvar g = 0; g < NCH; g++) begin : g_slice
    assign cur_w[g] = test_expr[g*W +: W];
    assign st_w[g]  = start_state[g*W +: W];
    assign nx_w[g]  = next_state[g*W +: W];
  end

  // Per-channel violation detection and FSM next state
  always_comb begin
    viol = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      wait_d[i]  = wait_q[i];
      if (!enable) begin
        state_d[i] = S_IDLE;
        wait_d[i]  = 8'd0;
      end else if (MODE == 0) begin
        viol[i] = prev_valid_q && (prev_q[i] == st_w[i]) &&
                  (cur_w[i] == nx_w[i]) && (st_w[i] != nx_w[i]);
      end else begin
        case (state_q[i])
          S_IDLE: begin
            // a channel whose start equals next can never be checked
            if ((cur_w[i] == st_w[i]) && (st_w[i] != nx_w[i])) begin
              state_d[i] = S_ARMED;
              wait_d[i]  = 8'd1;
            end
          end
          S_ARMED: begin
            if (cur_w[i] == nx_w[i]) begin
              state_d[i] = S_IDLE;
              wait_d[i]  = 8'd0;
            end else if (cur_w[i] == st_w[i]) begin
              if (wait_q[i] >= 8'(MAX_WAIT)) begin
                viol[i]    = 1'b1;
                state_d[i] = S_IDLE;
                wait_d[i]  = 8'd0;
              end else begin
                wait_d[i] = wait_q[i] + 8'd1;
              end
            end else begin
              viol[i]    = 1'b1;
              state_d[i] = S_IDLE;
              wait_d[i]  = 8'd0;
            end
          end
          default: begin
            state_d[i] = S_IDLE;
            wait_d[i]  = 8'd0;
          end
        endcase
      end
    end
  end

  // Channel state: previous sample, FSM, wait counter and registered fire pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        prev_q[i]  <= '0;
        state_q[i] <= S_IDLE;
        wait_q[i]  <= 8'd0;
      end
      prev_valid_q <= 1'b0;
      fire_q       <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (enable) begin
          prev_q[i] <= cur_w[i];
        end
        state_q[i] <= state_d[i];
        wait_q[i]  <= wait_d[i];
      end
      prev_valid_q <= enable;
      fire_q       <= viol;
    end
  end

  // Popcount of this edge's violations and the lowest violating channel
  always_comb begin
    pop    = '0;
    low_ch = '0;
    for (int i = 0; i < NCH; i++) begin
      pop = pop + PW'(viol[i]);
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (viol[i]) begin
        low_ch = FCH_W'(i);
      end
    end
  end

  // Saturating count; a same-edge clear discards the old total first
  always_comb begin
    sum = (clear ? '0 : SUM_W'(count_q)) + SUM_W'(pop);
    if (sum > SUM_W'({CNT_W{1'b1}})) begin
      count_d = {CNT_W{1'b1}};
    end else begin
      count_d = sum[CNT_W-1:0];
    end
  end

  // Sticky flags, count and first-failure record
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sticky_q <= '0;
      count_q  <= '0;
      ffv_q    <= 1'b0;
      ffc_q    <= '0;
    end else begin
      sticky_q <= (clear ? '0 : sticky_q) | viol;
      count_q  <= count_d;
      if (clear) begin
        ffv_q <= |viol;
        ffc_q <= (|viol) ? low_ch : '0;
      end else if (!ffv_q && (|viol)) begin
        ffv_q <= 1'b1;
        ffc_q <= low_ch;
      end
    end
  end

  assign fire             = fire_q;
  assign fire_sticky      = sticky_q;
  assign fire_count       = count_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_ch    = ffc_q;

endmodule

// File: tb/tb_ovl_transition_multi.sv
// tb/tb_ovl_transition_multi.sv - directed vector bench for ovl_transition_multi
module tb_ovl_transition_multi;

  typedef struct {
    logic       en;
    logic       clr;
    logic [3:0] st;
    logic [3:0] nx;
    logic [3:0] te;
    logic [1:0] f;
    logic [1:0] s;
    logic [7:0] c;
    logic [1:0] cs;
    logic       ffv;
    logic       ffc;
  } vec_t;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       clear;
  logic [3:0] te;
  logic [3:0] st;
  logic [3:0] nx;

  logic [1:0] f_m0, s_m0, f_sat, s_sat, f_m1, s_m1;
  logic [7:0] c_m0, c_m1;
  logic [1:0] c_sat;
  logic       v_m0, v_sat, v_m1;
  logic [0:0] ch_m0, ch_sat, ch_m1;

  int n_cmp;
  int n_fail;

  vec_t tbl0[$];
  vec_t tbl1[$];
  vec_t zero_v;

  ovl_transition_multi #(.NCH(2), .W(2), .MODE(0), .MAX_WAIT(4), .CNT_W(8)) u_m0 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .test_expr(te), .start_state(st), .next_state(nx),
    .fire(f_m0), .fire_sticky(s_m0), .fire_count(c_m0),
    .first_fail_valid(v_m0), .first_fail_ch(ch_m0)
  );

  ovl_transition_multi #(.NCH(2), .W(2), .MODE(0), .MAX_WAIT(4), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .test_expr(te), .start_state(st), .next_state(nx),
    .fire(f_sat), .fire_sticky(s_sat), .fire_count(c_sat),
    .first_fail_valid(v_sat), .first_fail_ch(ch_sat)
  );

  ovl_transition_multi #(.NCH(2), .W(2), .MODE(1), .MAX_WAIT(4), .CNT_W(8)) u_m1 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .test_expr(te), .start_state(st), .next_state(nx),
    .fire(f_m1), .fire_sticky(s_m1), .fire_count(c_m1),
    .first_fail_valid(v_m1), .first_fail_ch(ch_m1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic en, input logic clr, input logic [3:0] s_st,
                              input logic [3:0] s_nx, input logic [3:0] s_te,
                              input logic [1:0] f, input logic [1:0] s, input logic [7:0] c,
                              input logic [1:0] cs, input logic ffv, input logic ffc);
    vec_t v;
    v.en = en; v.clr = clr; v.st = s_st; v.nx = s_nx; v.te = s_te;
    v.f = f; v.s = s; v.c = c; v.cs = cs; v.ffv = ffv; v.ffc = ffc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_m0(input vec_t v, input int idx);
    chk("m0.fire", idx, 32'(f_m0), 32'(v.f));
    chk("m0.sticky", idx, 32'(s_m0), 32'(v.s));
    chk("m0.count", idx, 32'(c_m0), 32'(v.c));
    chk("m0.ff_valid", idx, 32'(v_m0), 32'(v.ffv));
    chk("m0.ff_ch", idx, 32'(ch_m0), 32'(v.ffc));
    chk("sat.count", idx, 32'(c_sat), 32'(v.cs));
  endtask

  task automatic check_m1(input vec_t v, input int idx);
    chk("m1.fire", idx, 32'(f_m1), 32'(v.f));
    chk("m1.sticky", idx, 32'(s_m1), 32'(v.s));
    chk("m1.count", idx, 32'(c_m1), 32'(v.c));
    chk("m1.ff_valid", idx, 32'(v_m1), 32'(v.ffv));
    chk("m1.ff_ch", idx, 32'(ch_m1), 32'(v.ffc));
  endtask

  task automatic run_row(input vec_t v, input int idx, input bit mode1);
    enable = v.en;
    clear  = v.clr;
    st     = v.st;
    nx     = v.nx;
    te     = v.te;
    @(posedge clock);
    #1;
    if (mode1) check_m1(v, idx);
    else check_m0(v, idx);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    zero_v = mk(0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 2'd0, 8'd0, 2'd0, 0, 0);

    // forbidden transition: ch0 3->0, ch1 1->2
    tbl0.push_back(mk(1, 0, 4'h7, 4'h8, 4'h3, 2'd0, 2'd0, 8'd0, 2'd0, 0, 0));
    tbl0.push_back(mk(1, 0, 4'h7, 4'h8, 4'h3, 2'd0, 2'd0, 8'd0, 2'd0, 0, 0));
    tbl0.push_back(mk(1, 0, 4'h7, 4'h8, 4'h0, 2'd1, 2'd1, 8'd1, 2'd1, 1, 0));
    tbl0.push_back(mk(1, 0, 4'h7, 4'h8, 4'h0, 2'd0, 2'd1, 8'd1, 2'd1, 1, 0));
    tbl0.push_back(mk(1, 0, 4'h7, 4'h8, 4'h7, 2'd0, 2'd1, 8'd1, 2'd1, 1, 0));
    tbl0.push_back(mk(1, 0, 4'h7, 4'h8, 4'h8, 2'd3, 2'd3, 8'd3, 2'd3, 1, 0));
    tbl0.push_back(mk(1, 0, 4'h7, 4'h8, 4'h7, 2'd0, 2'd3, 8'd3, 2'd3, 1, 0));
    tbl0.push_back(mk(1, 1, 4'h7, 4'h8, 4'hB, 2'd2, 2'd2, 8'd1, 2'd1, 1, 1));
    tbl0.push_back(mk(1, 1, 4'h7, 4'h8, 4'hB, 2'd0, 2'd0, 8'd0, 2'd0, 0, 0));
    tbl0.push_back(mk(1, 0, 4'h7, 4'h8, 4'h7, 2'd0, 2'd0, 8'd0, 2'd0, 0, 0));
    tbl0.push_back(mk(0, 0, 4'h7, 4'h8, 4'h8, 2'd0, 2'd0, 8'd0, 2'd0, 0, 0));
    tbl0.push_back(mk(1, 0, 4'h7, 4'h8, 4'h8, 2'd0, 2'd0, 8'd0, 2'd0, 0, 0));
    tbl0.push_back(mk(1, 0, 4'h6, 4'hA, 4'h2, 2'd0, 2'd0, 8'd0, 2'd0, 0, 0));
    tbl0.push_back(mk(1, 0, 4'h6, 4'hA, 4'h2, 2'd0, 2'd0, 8'd0, 2'd0, 0, 0));
    tbl0.push_back(mk(1, 0, 4'h7, 4'h8, 4'h7, 2'd0, 2'd0, 8'd0, 2'd0, 0, 0));
    tbl0.push_back(mk(1, 0, 4'h7, 4'h8, 4'h8, 2'd3, 2'd3, 8'd2, 2'd2, 1, 0));
    tbl0.push_back(mk(1, 0, 4'h7, 4'h8, 4'h7, 2'd0, 2'd3, 8'd2, 2'd2, 1, 0));
    tbl0.push_back(mk(1, 0, 4'h7, 4'h8, 4'h8, 2'd3, 2'd3, 8'd4, 2'd3, 1, 0));
    tbl0.push_back(mk(1, 0, 4'h7, 4'h8, 4'h7, 2'd0, 2'd3, 8'd4, 2'd3, 1, 0));
    tbl0.push_back(mk(1, 0, 4'h7, 4'h8, 4'h8, 2'd3, 2'd3, 8'd6, 2'd3, 1, 0));

    // required transition: both channels start=1 next=2
    for (int i = 0; i < 4; i++) tbl1.push_back(mk(1, 0, 4'h5, 4'hA, 4'h4, 2'd0, 2'd0, 8'd0, 2'd0, 0, 0));
    tbl1.push_back(mk(1, 0, 4'h5, 4'hA, 4'h4, 2'd2, 2'd2, 8'd1, 2'd0, 1, 1));
    for (int i = 0; i < 4; i++) tbl1.push_back(mk(1, 0, 4'h5, 4'hA, 4'h4, 2'd0, 2'd2, 8'd1, 2'd0, 1, 1));
    tbl1.push_back(mk(1, 0, 4'h5, 4'hA, 4'h4, 2'd2, 2'd2, 8'd2, 2'd0, 1, 1));
    tbl1.push_back(mk(1, 0, 4'h5, 4'hA, 4'h0, 2'd0, 2'd2, 8'd2, 2'd0, 1, 1));
    tbl1.push_back(mk(1, 0, 4'h5, 4'hA, 4'h1, 2'd0, 2'd2, 8'd2, 2'd0, 1, 1));
    tbl1.push_back(mk(1, 0, 4'h5, 4'hA, 4'h3, 2'd1, 2'd3, 8'd3, 2'd0, 1, 1));
    tbl1.push_back(mk(1, 0, 4'h5, 4'hA, 4'h1, 2'd0, 2'd3, 8'd3, 2'd0, 1, 1));
    tbl1.push_back(mk(1, 0, 4'h5, 4'hA, 4'h1, 2'd0, 2'd3, 8'd3, 2'd0, 1, 1));
    tbl1.push_back(mk(1, 0, 4'h5, 4'hA, 4'h2, 2'd0, 2'd3, 8'd3, 2'd0, 1, 1));
    tbl1.push_back(mk(1, 0, 4'h5, 4'hA, 4'h1, 2'd0, 2'd3, 8'd3, 2'd0, 1, 1));
    tbl1.push_back(mk(0, 0, 4'h5, 4'hA, 4'h3, 2'd0, 2'd3, 8'd3, 2'd0, 1, 1));
    tbl1.push_back(mk(1, 0, 4'h5, 4'hA, 4'h3, 2'd0, 2'd3, 8'd3, 2'd0, 1, 1));
    tbl1.push_back(mk(1, 0, 4'h5, 4'hA, 4'h1, 2'd0, 2'd3, 8'd3, 2'd0, 1, 1));
    tbl1.push_back(mk(1, 1, 4'h5, 4'hA, 4'h3, 2'd1, 2'd1, 8'd1, 2'd0, 1, 0));
    for (int i = 0; i < 6; i++) tbl1.push_back(mk(1, 0, 4'h5, 4'h5, 4'h1, 2'd0, 2'd1, 8'd1, 2'd0, 1, 0));
    for (int i = 0; i < 3; i++) tbl1.push_back(mk(1, 0, 4'h5, 4'hA, 4'h4, 2'd0, 2'd1, 8'd1, 2'd0, 1, 0));

    reset  = 1'b1;
    enable = 1'b0;
    clear  = 1'b0;
    te     = '0;
    st     = '0;
    nx     = '0;
    #2;
    check_m0(zero_v, -1);
    check_m1(zero_v, -1);
    @(negedge clock);
    reset = 1'b0;

    foreach (tbl0[i]) run_row(tbl0[i], i, 1'b0);

    // async reset between edges while ch0 sits at start; the following 3->0 must not fire
    run_row(mk(1, 0, 4'h7, 4'h8, 4'h3, 2'd0, 2'd3, 8'd6, 2'd3, 1, 0), 100, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_m0(zero_v, 101);
    @(negedge clock);
    reset = 1'b0;
    run_row(mk(1, 0, 4'h7, 4'h8, 4'h0, 2'd0, 2'd0, 8'd0, 2'd0, 0, 0), 102, 1'b0);

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    foreach (tbl1[i]) run_row(tbl1[i], 200 + i, 1'b1);

    // reset while ch1 is armed for 3 edges: the wait restarts from scratch
    #2;
    reset = 1'b1;
    #1;
    check_m1(zero_v, 300);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) run_row(mk(1, 0, 4'h5, 4'hA, 4'h4, 2'd0, 2'd0, 8'd0, 2'd0, 0, 0), 301 + i, 1'b1);
    run_row(mk(1, 0, 4'h5, 4'hA, 4'h4, 2'd2, 2'd2, 8'd1, 2'd0, 1, 1), 305, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
